mdl_oob_detect: RTL and testbench
=================================

// Module: mdl_oob_detect
// PURPOSE
//  Bench model of the device-side OOB squelch/detector. Sits upstream of the device OOB model.
//  Watches the host serial line (rx_p/rx_n) and measures burst and idle lengths in bit-clock ticks.
//  Classifies COMRESET-type (160 on / 480 off) and COMWAKE-type (160 on / 160 off) trains.
//  Produces the comreset/comwake detect levels and the comfinish pulse the device OOB model consumes.
//  Also flags continuous signalling (ALIGN/SYNC traffic) as line-active.
// PARAMETERS
//  UIOOB        160  nominal burst length, ticks
//  BURST_TOL    16   burst valid if length in [UIOOB-BURST_TOL, UIOOB+BURST_TOL]
//  RESET_IDLE   480  nominal COMRESET/COMINIT gap, ticks
//  WAKE_IDLE    160  nominal COMWAKE gap, ticks
//  IDLE_TOL     16   gap valid if within +/-IDLE_TOL of the nominal value
//  N_DET        4    consecutive valid same-type bursts needed for detection
//  FINISH_IDLE  800  idle ticks after a detected train before comfinish; must exceed RESET_IDLE+IDLE_TOL
//  SQUELCH      2    consecutive equal raw samples needed to change the filtered line state
// PORTS
//  i_clk           in   1  bit-rate clock, 1 tick = 1 UI
//  i_rst           in   1  synchronous, active-high reset
//  i_rx_p          in   1  serial line, positive leg
//  i_rx_n          in   1  serial line, negative leg
//  o_comreset_det  out  1  level: COMRESET/COMINIT train detected
//  o_comwake_det   out  1  level: COMWAKE train detected
//  o_comfinish     out  1  1-cycle pulse: detected train has ended (line quiet FINISH_IDLE)
//  o_active        out  1  level: continuous signalling present (burst longer than the valid window)
// BEHAVIOUR
//  - Reset: i_rst is synchronous, active-high; clock is i_clk. All outputs 0, FSM S_SILENT, counters 0, filtered line 0.
//  - Reset mid-operation clears everything on the next edge; no partial train survives.
//  - Raw activity: act = i_rx_p ^ i_rx_n. Electrical idle is i_rx_p == i_rx_n.
//  - sq: filtered act. Toggles only after SQUELCH consecutive raw samples differ from the current sq.
//    Shorter glitches are ignored. The delay is fixed, so measured lengths are preserved.
//  - blen counts burst ticks; width clog2(UIOOB+BURST_TOL+2); saturating.
//  - glen counts gap ticks; width clog2(FINISH_IDLE+1); saturating.
//  - train_cnt counts valid bursts, saturating at N_DET. ttype is one of NONE, RESET, WAKE.
//  FSM:
//  - S_SILENT: sq rise -> S_BURST; blen=1, train_cnt=0, ttype=NONE.
//  - S_BURST:
//    - blen++ each cycle.
//    - blen > UIOOB+BURST_TOL -> S_ACTIVE; o_active=1; train cleared (train_cnt=0, ttype=NONE).
//    - sq fall with blen in window -> S_GAP; glen=1; train_cnt++.
//    - sq fall with blen out of window -> S_SILENT; train cleared.
//  - S_GAP:
//    - glen++ each cycle.
//    - On sq rise, classify glen: RESET window, WAKE window, or invalid.
//      - Invalid gap, or type differs from a non-NONE ttype: new burst starts a fresh train (train_cnt=0, ttype=NONE).
//      - Otherwise ttype = class.
//      - Either way -> S_BURST with blen=1.
//    - glen == FINISH_IDLE -> S_SILENT. If train_cnt >= N_DET and ttype != NONE, pulse o_comfinish.
//  - S_ACTIVE: o_active stays 1 while sq=1. sq fall -> S_SILENT, o_active=0 on the same edge.
//  Detection:
//  - Fires on the burst end that brings train_cnt to N_DET with ttype set.
//  - Sets the matching det output and clears the other. Latency: SQUELCH+1 cycles after raw line idle.
//  - Det levels are sticky through comfinish. A det output clears only on detection of the opposite type, or on reset.
//  - Bursts beyond N_DET keep the train valid (train_cnt saturates); no re-pulse of det.
//  Simultaneous events:
//  - A gap timing out at exactly the same cycle as sq rise is a rise (classification wins).
//  - A comfinish pulse and a new detection never coincide; the FSM is in distinct states for each.
// STRUCTURE
//  - Shared package mdl_oob_pkg: UIOOB, COMRESET/COMWAKE nominal timings, tolerances, and the ttype enum localparams.
//    The device OOB model and the line transmit model use the same package.
//  - One natural sub-module: mdl_oob_squelch (SQUELCH-sample glitch filter, outputs sq).
//  - FSM, counters and classification stay in this module.
// TESTING
//  1. 6 bursts 160 on / 480 off, then 1000 idle -> o_comreset_det=1 at 3 cycles after the 4th raw burst end;
//     o_comfinish pulses once, 800 filtered idle ticks after burst 6; o_comwake_det stays 0.
//  2. After test 1: 6 bursts 160/160, then idle -> o_comwake_det=1 and o_comreset_det=0 after burst 4;
//     one o_comfinish pulse.
//  3. Reset train with a 300-tick gap after burst 2 -> no det at burst 4; burst 3 starts a new train;
//     det after burst 6.
//  4. Continuous differential drive for 2000 ticks -> o_active=1 at 177+SQUELCH ticks after the raw rise; no det, no finish;
//     drive idle -> o_active=0 after SQUELCH+1 cycles.
//  5. 1-tick raw glitch mid-gap -> ignored, train detected normally.
//     A burst of 130 ticks -> train aborted, no det for that train.
//  6. i_rst pulsed during burst 3 of a reset train -> all outputs 0 next cycle;
//     a following clean 4-burst train is detected normally.

Source files
------------

// File: rtl/mdl_oob_pkg.sv
// rtl/mdl_oob_pkg.sv - shared OOB timing constants, train type and gap classifier
package mdl_oob_pkg;

    localparam int UIOOB       = 160;
    localparam int BURST_TOL   = 16;
    localparam int RESET_IDLE  = 480;
    localparam int WAKE_IDLE   = 160;
    localparam int IDLE_TOL    = 16;
    localparam int N_DET       = 4;
    localparam int FINISH_IDLE = 800;
    localparam int SQUELCH     = 2;

    localparam int BLEN_W = $clog2(UIOOB + BURST_TOL + 2);
    localparam int GLEN_W = $clog2(FINISH_IDLE + 1);
    localparam int TCNT_W = $clog2(N_DET + 1);

    localparam logic [BLEN_W-1:0] BLEN_LO  = BLEN_W'(UIOOB - BURST_TOL);
    localparam logic [BLEN_W-1:0] BLEN_HI  = BLEN_W'(UIOOB + BURST_TOL);
    localparam logic [GLEN_W-1:0] GLEN_FIN = GLEN_W'(FINISH_IDLE);
    localparam logic [TCNT_W-1:0] TCNT_DET = TCNT_W'(N_DET);

    typedef enum logic [1:0] {
        TT_NONE  = 2'd0,
        TT_RESET = 2'd1,
        TT_WAKE  = 2'd2
    } ttype_e;

    function automatic ttype_e classify_gap(input logic [GLEN_W-1:0] glen);
        if (glen >= GLEN_W'(RESET_IDLE - IDLE_TOL) && glen <= GLEN_W'(RESET_IDLE + IDLE_TOL))
            return TT_RESET;
        if (glen >= GLEN_W'(WAKE_IDLE - IDLE_TOL) && glen <= GLEN_W'(WAKE_IDLE + IDLE_TOL))
            return TT_WAKE;
        return TT_NONE;
    endfunction

endpackage

// File: rtl/mdl_oob_detect_if.sv
// rtl/mdl_oob_detect_if.sv - serial line inputs and detect outputs of the OOB detector
interface mdl_oob_detect_if;

    logic i_rx_p;
    logic i_rx_n;
    logic o_comreset_det;
    logic o_comwake_det;
    logic o_comfinish;
    logic o_active;

    modport master (
        output i_rx_p, i_rx_n,
        input  o_comreset_det, o_comwake_det, o_comfinish, o_active
    );

    modport slave (
        input  i_rx_p, i_rx_n,
        output o_comreset_det, o_comwake_det, o_comfinish, o_active
    );

endinterface

// File: rtl/mdl_oob_squelch.sv
// rtl/mdl_oob_squelch.sv - glitch filter: sq follows act after SQUELCH agreeing samples
module mdl_oob_squelch
    import mdl_oob_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_act,
    output logic o_sq
);

    localparam int CNT_W = $clog2(SQUELCH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SQUELCH - 1);

    logic             sq_q, sq_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Both edges see the same delay, so burst and gap lengths pass through unchanged.
    always_comb begin
        sq_d  = sq_q;
        cnt_d = '0;
        if (i_act != sq_q) begin
            if (cnt_q == CNT_LAST) sq_d = i_act;
            else                   cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sq_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            sq_q  <= sq_d;
            cnt_q <= cnt_d;
        end
    end

    assign o_sq = sq_q;

endmodule

// File: rtl/mdl_oob_detect.sv
// rtl/mdl_oob_detect.sv - measures filtered burst/gap lengths and classifies COMRESET/COMWAKE trains
module mdl_oob_detect
    import mdl_oob_pkg::*;
(
    input logic             i_clk,
    input logic             i_rst,
    mdl_oob_detect_if.slave oob
);

    localparam logic [1:0] S_SILENT = 2'd0;
    localparam logic [1:0] S_BURST  = 2'd1;
    localparam logic [1:0] S_GAP    = 2'd2;
    localparam logic [1:0] S_ACTIVE = 2'd3;

    logic              sq;
    logic [1:0]        state_q, state_d;
    logic [BLEN_W-1:0] blen_q, blen_d;
    logic [GLEN_W-1:0] glen_q, glen_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    ttype_e            ttype_q, ttype_d;
    ttype_e            gap_cls;
    logic              det_r_q, det_r_d;
    logic              det_w_q, det_w_d;
    logic              fin_q, fin_d;
    logic              act_q, act_d;

    mdl_oob_squelch u_squelch (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_act (oob.i_rx_p ^ oob.i_rx_n),
        .o_sq  (sq)
    );

    assign gap_cls = classify_gap(glen_q);

    always_comb begin
        state_d = state_q;
        blen_d  = blen_q;
        glen_d  = glen_q;
        tcnt_d  = tcnt_q;
        ttype_d = ttype_q;
        det_r_d = det_r_q;
        det_w_d = det_w_q;
        fin_d   = 1'b0;
        act_d   = act_q;
        case (state_q)
            S_SILENT: begin
                if (sq) begin
                    state_d = S_BURST;
                    blen_d  = BLEN_W'(1);
                    tcnt_d  = '0;
                    ttype_d = TT_NONE;
                end
            end
            S_BURST: begin
                if (!sq) begin
                    if (blen_q >= BLEN_LO && blen_q <= BLEN_HI) begin
                        state_d = S_GAP;
                        glen_d  = GLEN_W'(1);
                        if (tcnt_q != TCNT_DET) begin
                            tcnt_d = tcnt_q + 1'b1;
                            // Detection happens only on the burst that completes the train.
                            if (tcnt_q == TCNT_DET - 1'b1 && ttype_q != TT_NONE) begin
                                det_r_d = (ttype_q == TT_RESET);
                                det_w_d = (ttype_q == TT_WAKE);
                            end
                        end
                    end else begin
                        state_d = S_SILENT;
                        tcnt_d  = '0;
                        ttype_d = TT_NONE;
                    end
                end else if (blen_q >= BLEN_HI) begin
                    state_d = S_ACTIVE;
                    act_d   = 1'b1;
                    tcnt_d  = '0;
                    ttype_d = TT_NONE;
                end else begin
                    blen_d = blen_q + 1'b1;
                end
            end
            S_GAP: begin
                // A rise on the timeout cycle is classified rather than timed out.
                if (sq) begin
                    state_d = S_BURST;
                    blen_d  = BLEN_W'(1);
                    if (gap_cls == TT_NONE || (ttype_q != TT_NONE && gap_cls != ttype_q)) begin
                        tcnt_d  = '0;
                        ttype_d = TT_NONE;
                    end else begin
                        ttype_d = gap_cls;
                    end
                end else if (glen_q == GLEN_FIN) begin
                    state_d = S_SILENT;
                    fin_d   = (tcnt_q >= TCNT_DET) && (ttype_q != TT_NONE);
                end else begin
                    glen_d = glen_q + 1'b1;
                end
            end
            default: begin
                if (!sq) begin
                    state_d = S_SILENT;
                    act_d   = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_SILENT;
            blen_q  <= '0;
            glen_q  <= '0;
            tcnt_q  <= '0;
            ttype_q <= TT_NONE;
            det_r_q <= 1'b0;
            det_w_q <= 1'b0;
            fin_q   <= 1'b0;
            act_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            blen_q  <= blen_d;
            glen_q  <= glen_d;
            tcnt_q  <= tcnt_d;
            ttype_q <= ttype_d;
            det_r_q <= det_r_d;
            det_w_q <= det_w_d;
            fin_q   <= fin_d;
            act_q   <= act_d;
        end
    end

    assign oob.o_comreset_det = det_r_q;
    assign oob.o_comwake_det  = det_w_q;
    assign oob.o_comfinish    = fin_q;
    assign oob.o_active       = act_q;

endmodule

// File: tb/tb_mdl_oob_detect.sv
// tb/tb_mdl_oob_detect.sv - scoreboard bench for mdl_oob_detect driven by burst/gap trains
module tb_mdl_oob_detect;

    logic i_clk = 1'b0;
    logic i_rst;

    mdl_oob_detect_if oob();

    mdl_oob_detect dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .oob   (oob)
    );

    always #5 i_clk = ~i_clk;

    int edge_n = 0;
    always @(posedge i_clk) edge_n <= edge_n + 1;

    typedef struct {
        int         cyc;
        logic [3:0] vec;
    } ev_t;

    ev_t        exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic       mon_en = 1'b0;
    logic [3:0] prev_vec;

    // Expected output vector {comreset_det, comwake_det, comfinish, active} and train state.
    logic [3:0] m_vec  = 4'b0000;
    int         m_cnt  = 0;
    int         m_type = 0;
    logic       m_gap  = 1'b0;

    int on_a[$];
    int off_a[$];
    int gl_a[$];

    always @(negedge i_clk) begin : monitor
        logic [3:0] v;
        ev_t        x;
        v = {oob.o_comreset_det, oob.o_comwake_det, oob.o_comfinish, oob.o_active};
        if (!mon_en) begin
            prev_vec = v;
        end else if (v !== prev_vec) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_event: cycle %0d outputs %b, required no change", edge_n, v);
            end else begin
                x = exp_q.pop_front();
                if (x.cyc != edge_n || x.vec !== v) begin
                    n_bad++;
                    $display("FAIL event: cycle %0d outputs %b, required cycle %0d outputs %b",
                             edge_n, v, x.cyc, x.vec);
                end
            end
            prev_vec = v;
        end
    end

    function automatic int gap_class(input int g);
        if (g >= 480 - 16 && g <= 480 + 16) return 1;
        if (g >= 160 - 16 && g <= 160 + 16) return 2;
        return 0;
    endfunction

    task automatic push(input int c, input logic [3:0] v);
        ev_t x;
        if (v != m_vec) begin
            x.cyc = c;
            x.vec = v;
            exp_q.push_back(x);
            m_vec = v;
        end
    endtask

    // Raw line: burst start at cycle t is seen by the classifier 2 cycles later (squelch delay).
    task automatic model_phase(input int t0, input int rst_burst, input int rst_len);
        int t, l, g, s, e, cls;
        t = t0;
        for (int i = 0; i < on_a.size(); i++) begin
            if (i == rst_burst) begin
                push(t + rst_len, 4'b0000);
                m_cnt = 0;
                m_type = 0;
                m_gap = 1'b0;
                return;
            end
            l = on_a[i];
            s = t + 2;
            e = t + l + 2;
            if (!m_gap) begin
                m_cnt = 0;
                m_type = 0;
            end else begin
                cls = gap_class(off_a[i-1]);
                if (cls == 0 || (m_type != 0 && m_type != cls)) begin
                    m_cnt = 0;
                    m_type = 0;
                end else begin
                    m_type = cls;
                end
            end
            if (l > 176) begin
                push(s + 176, m_vec | 4'b0001);
                push(e, m_vec & 4'b1110);
                m_cnt = 0;
                m_type = 0;
                m_gap = 1'b0;
            end else if (l >= 144) begin
                m_gap = 1'b1;
                if (m_cnt < 4) begin
                    m_cnt++;
                    if (m_cnt == 4 && m_type != 0)
                        push(e, {m_type == 1, m_type == 2, m_vec[1:0]});
                end
            end else begin
                m_cnt = 0;
                m_type = 0;
                m_gap = 1'b0;
            end
            g = off_a[i];
            if (m_gap && g > 800) begin
                if (m_cnt >= 4 && m_type != 0) begin
                    push(e + 800, m_vec | 4'b0010);
                    push(e + 801, m_vec & 4'b1101);
                end
                m_gap = 1'b0;
            end
            t = t + l + g;
        end
    endtask

    task automatic tick(input logic act, input logic rst);
        logic b;
        b = 1'($urandom);
        oob.i_rx_p = b;
        oob.i_rx_n = act ? ~b : b;
        i_rst = rst;
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_phase();
        on_a.delete();
        off_a.delete();
        gl_a.delete();
    endtask

    task automatic add(input int n, input int on, input int off, input int gl);
        for (int i = 0; i < n; i++) begin
            on_a.push_back(on);
            off_a.push_back(off);
            gl_a.push_back(gl);
        end
    endtask

    task automatic run_phase(input int rst_burst, input int rst_len);
        model_phase(edge_n + 1, rst_burst, rst_len);
        for (int i = 0; i < on_a.size(); i++) begin
            if (i == rst_burst) begin
                for (int k = 0; k < rst_len; k++) tick(1'b1, 1'b0);
                tick(1'b0, 1'b1);
                repeat (20) tick(1'b0, 1'b0);
                return;
            end
            for (int k = 0; k < on_a[i]; k++) tick(1'b1, 1'b0);
            for (int k = 0; k < off_a[i]; k++)
                tick((gl_a[i] != 0 && k == gl_a[i]) ? 1'b1 : 1'b0, 1'b0);
        end
    endtask

    task automatic rand_phase();
        int n, ty, nom, on, off, gl;
        clear_phase();
        n = $urandom_range(7, 4);
        ty = $urandom_range(2, 1);
        nom = (ty == 1) ? 480 : 160;
        for (int i = 0; i < n; i++) begin
            on = 160 + $urandom_range(44, 0) - 22;
            off = (i == n - 1) ? 1000 : nom + $urandom_range(44, 0) - 22;
            gl = ($urandom_range(3, 0) == 0 && i < n - 1) ? off / 2 : 0;
            add(1, on, off, gl);
        end
        run_phase(-1, 0);
    endtask

    initial begin
        i_rst = 1'b1;
        oob.i_rx_p = 1'b0;
        oob.i_rx_n = 1'b0;
        repeat (3) tick(1'b0, 1'b1);
        n_cmp++;
        if ({oob.o_comreset_det, oob.o_comwake_det, oob.o_comfinish, oob.o_active} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_state: outputs %b, required 0000",
                     {oob.o_comreset_det, oob.o_comwake_det, oob.o_comfinish, oob.o_active});
        end
        mon_en = 1'b1;
        repeat (5) tick(1'b0, 1'b0);

        // COMRESET train, then COMWAKE train
        clear_phase(); add(5, 160, 480, 0); add(1, 160, 1000, 0); run_phase(-1, 0);
        clear_phase(); add(5, 160, 160, 0); add(1, 160, 1000, 0); run_phase(-1, 0);
        // gap of exactly FINISH_IDLE is a rise, not a timeout
        clear_phase(); add(3, 160, 480, 0); add(1, 160, 800, 0); add(1, 160, 1000, 0); run_phase(-1, 0);
        // burst and gap window edges
        clear_phase();
        add(1, 144, 144, 0); add(1, 176, 176, 0); add(1, 144, 176, 0); add(1, 176, 1000, 0);
        run_phase(-1, 0);
        // invalid 300-tick gap restarts the train
        clear_phase();
        add(1, 160, 480, 0); add(1, 160, 300, 0); add(3, 160, 480, 0); add(1, 160, 1000, 0);
        run_phase(-1, 0);
        // continuous signalling
        clear_phase(); add(1, 2000, 1000, 0); run_phase(-1, 0);
        // glitch mid-gap is ignored
        clear_phase(); add(1, 160, 160, 0); add(4, 160, 160, 80); add(1, 160, 1000, 0); run_phase(-1, 0);
        // 130-tick burst aborts the train
        clear_phase();
        add(2, 160, 480, 0); add(1, 130, 480, 0); add(1, 160, 480, 0); add(1, 160, 1000, 0);
        run_phase(-1, 0);
        // reset in burst 3, then a clean train
        clear_phase(); add(4, 160, 480, 0); run_phase(2, 80);
        clear_phase(); add(3, 160, 480, 0); add(1, 160, 1000, 0); run_phase(-1, 0);

        for (int p = 0; p < 5; p++) rand_phase();

        repeat (20) tick(1'b0, 1'b0);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL missing_events: %0d expected events never seen, first at cycle %0d outputs %b",
                     exp_q.size(), exp_q[0].cyc, exp_q[0].vec);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
